// File: rtl/m_unit_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Defining M_UNIT_SINGLE_CYCLE_MUL_EN replaces the iterative multiply with a combinational one.
module m_unit_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      dest,
  output logic            busy,
  output logic            m_unit_ready,
  output logic [XLEN-1:0] m_unit_result,
  output logic            m_unit_wr,
  output logic [4:0]      m_unit_dest
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [1:0]        op_r;
  logic              neg_r;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   a_r;
  logic [2*XLEN-1:0] b_r;
  logic [2*XLEN-1:0] acc_r;

  logic              op1_sgn, op2_sgn, op1_neg, op2_neg, res_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, special_res;
  logic [XLEN:0]     rem_sh, dvsr, rem_new;
  logic              ge, last;
  logic [XLEN-1:0]   a_nxt, quo_fin, rem_fin, fin_res;
  logic [2*XLEN-1:0] b_nxt, acc_nxt, mul_fin;

  assign busy = (state != IDLE);

  always_comb begin
    op1_sgn  = func3[2] ? ~func3[0] : (func3[1:0] == 2'd1 || func3[1:0] == 2'd2);
    op2_sgn  = func3[2] ? ~func3[0] : (func3[1:0] == 2'd1);
    op1_neg  = op1_sgn & op1[XLEN-1];
    op2_neg  = op2_sgn & op2[XLEN-1];
    mag1     = op1_neg ? -op1 : op1;
    mag2     = op2_neg ? -op2 : op2;
    // remainder takes the dividend's sign, everything else the product/quotient sign
    res_neg  = (func3[2] & func3[1]) ? op1_neg : (op1_neg ^ op2_neg);
    div_zero = (op2 == '0);
    div_ovf  = ~func3[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);
    if (div_zero) special_res = func3[1] ? op1 : '1;
    else          special_res = func3[1] ? '0 : op1;
  end

  // Next-step datapath; the final iteration's result is sign-corrected in the same cycle.
  always_comb begin
    rem_sh  = {acc_r[XLEN-1:0], a_r[XLEN-1]};
    dvsr    = {1'b0, b_r[XLEN-1:0]};
    ge      = (rem_sh >= dvsr);
    rem_new = ge ? (rem_sh - dvsr) : rem_sh;
    if (state == DIV) begin
      acc_nxt = {{(XLEN-1){1'b0}}, rem_new};
      a_nxt   = {a_r[XLEN-2:0], ge};
      b_nxt   = b_r;
    end else begin
      acc_nxt = a_r[0] ? (acc_r + b_r) : acc_r;
      a_nxt   = a_r >> 1;
      b_nxt   = b_r << 1;
    end
    mul_fin = neg_r ? -acc_nxt : acc_nxt;
    quo_fin = neg_r ? -a_nxt : a_nxt;
    rem_fin = neg_r ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    if (state == DIV) fin_res = op_r[1] ? rem_fin : quo_fin;
    else              fin_res = (op_r == 2'd0) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
    last = (cnt_r == CW'(XLEN-1));
  end

`ifdef M_UNIT_SINGLE_CYCLE_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_fin;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    fast_fin  = res_neg ? -fast_prod : fast_prod;
    fast_res  = (func3[1:0] == 2'd0) ? fast_fin[XLEN-1:0] : fast_fin[2*XLEN-1:XLEN];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_r          <= '0;
      neg_r         <= 1'b0;
      cnt_r         <= '0;
      a_r           <= '0;
      b_r           <= '0;
      acc_r         <= '0;
      m_unit_ready  <= 1'b0;
      m_unit_wr     <= 1'b0;
      m_unit_result <= '0;
      m_unit_dest   <= '0;
    end else if (flush) begin
      state        <= IDLE;
      m_unit_ready <= 1'b0;
      m_unit_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_unit_ready <= 1'b0;
          m_unit_wr    <= 1'b0;
          if (start) begin
            op_r        <= func3[1:0];
            neg_r       <= res_neg;
            m_unit_dest <= dest;
            cnt_r       <= '0;
            a_r         <= mag1;
            b_r         <= {{XLEN{1'b0}}, mag2};
            acc_r       <= '0;
            if (func3[2]) begin
              if (div_zero || div_ovf) begin
                state         <= DONE;
                m_unit_result <= special_res;
                m_unit_ready  <= 1'b1;
                m_unit_wr     <= (dest != 5'd0);
              end else begin
                state <= DIV;
              end
            end else begin
`ifdef M_UNIT_SINGLE_CYCLE_MUL_EN
              state         <= DONE;
              m_unit_result <= fast_res;
              m_unit_ready  <= 1'b1;
              m_unit_wr     <= (dest != 5'd0);
`else
              state <= MUL;
`endif
            end
          end
        end
        MUL, DIV: begin
          a_r   <= a_nxt;
          b_r   <= b_nxt;
          acc_r <= acc_nxt;
          cnt_r <= cnt_r + CW'(1);
          if (last) begin
            state         <= DONE;
            m_unit_result <= fin_res;
            m_unit_ready  <= 1'b1;
            m_unit_wr     <= (m_unit_dest != 5'd0);
          end
        end
        DONE: begin
          state        <= IDLE;
          m_unit_ready <= 1'b0;
          m_unit_wr    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_unit_iterative.sv
// Directed bench for m_unit_iterative: reference model feeds a scoreboard, results checked on completion.
module tb_m_unit_iterative;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  dest;
  logic        busy, m_unit_ready, m_unit_wr;
  logic [31:0] m_unit_result;
  logic [4:0]  m_unit_dest;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        wr;
    int          lat;
  } exp_t;
  exp_t sb[$];

  m_unit_iterative #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .func3(func3),
    .op1(op1), .op2(op2), .dest(dest), .busy(busy), .m_unit_ready(m_unit_ready),
    .m_unit_result(m_unit_result), .m_unit_wr(m_unit_wr), .m_unit_dest(m_unit_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb2, sp;
    logic [63:0]        up;
    logic signed [31:0] x, y;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    x   = a;
    y   = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb2; return sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else if (ovf) return a;
        else return x / y;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        else if (ovf) return 32'h0;
        else return x % y;
      end
      default: begin
        if (b == 0) return a;
        else return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return LAT;
  endfunction

  // n counts rising edges from the accepting edge (n==1) to the one that raises m_unit_ready
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input string tag, input int intrude_at);
    exp_t e;
    int   n;
    logic seen;
    e.res  = ref_res(f, a, b);
    e.dest = d;
    e.wr   = (d != 0);
    e.lat  = ref_lat(f, a, b);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; func3 = f; op1 = a; op2 = b; dest = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 || (intrude_at > 0 && n == intrude_at + 1)) begin
        start = 1'b0; op1 = $urandom; op2 = $urandom; func3 = 3'($urandom); dest = 5'($urandom);
      end
      if (intrude_at > 0 && n == intrude_at) begin
        start = 1'b1; func3 = 3'd4; op1 = 32'd100; op2 = 32'd7; dest = 5'd3;
      end
      seen = m_unit_ready;
    end
    e = sb.pop_front();
    check({tag, ":ready"}, 64'(seen), 64'd1);
    check({tag, ":latency"}, 64'(n), 64'(e.lat));
    if (seen) begin
      check({tag, ":result"}, 64'(m_unit_result), 64'(e.res));
      check({tag, ":wr"}, 64'(m_unit_wr), 64'(e.wr));
      check({tag, ":dest"}, 64'(m_unit_dest), 64'(e.dest));
    end
    @(posedge clk); #1;
    check({tag, ":pulse_end"}, {62'b0, m_unit_ready, busy}, 64'd0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(m_unit_ready), 64'd0);
    check("rst_wr", 64'(m_unit_wr), 64'd0);
    check("rst_result", 64'(m_unit_result), 64'd0);
    check("rst_dest", 64'(m_unit_dest), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul", 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, "mulh", 0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd8, "mulhu", 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, "mulhsu", 0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, "mul_big", 0);
    run_op(3'd1, 32'hFFFF_FFFB, 32'd3, 5'd11, "mulh_neg", 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, "div", 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd13, "rem", 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd14, "divu_zero", 0);
    run_op(3'd7, 32'd5, 32'd0, 5'd15, "remu_zero", 0);
    run_op(3'd4, 32'd100, 32'd0, 5'd16, "div_zero", 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, "div_ovf", 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, "rem_ovf", 0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd19, "div_negneg", 0);
    run_op(3'd6, 32'd100, 32'hFFFF_FFF9, 5'd20, "rem_pos_neg", 0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd3, 5'd21, "divu_big", 0);
    run_op(3'd7, 32'd1000, 32'd7, 5'd22, "remu", 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd0, "dest0", 0);

    run_op(3'd0, 32'd11, 32'd13, 5'd4, "busy_ignore", 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_queued_op", 64'(busy), 64'd0);
    end

    // flush ten cycles into a DIVU
    @(negedge clk);
    start = 1'b1; func3 = 3'd5; op1 = 32'd1000; op2 = 32'd3; dest = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_ready", 64'(m_unit_ready), 64'd0);
    @(posedge clk); #1;
    check("flush_ready_later", 64'(m_unit_ready), 64'd0);
    run_op(3'd5, 32'd1000, 32'd3, 5'd2, "after_flush", 0);

    // reset in the middle of a MULH
    @(negedge clk);
    start = 1'b1; func3 = 3'd1; op1 = 32'h0001_2345; op2 = 32'h0000_0777; dest = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(m_unit_ready), 64'd0);
    check("midrst_wr", 64'(m_unit_wr), 64'd0);
    check("midrst_result", 64'(m_unit_result), 64'd0);
    check("midrst_dest", 64'(m_unit_dest), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_unit_ready || busy) seen = 1'b1;
    end
    check("midrst_no_pulse", 64'(seen), 64'd0);
    run_op(3'd7, 32'd12345, 32'd100, 5'd1, "post_reset", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
